// File: rtl/button_event_decoder_pkg.sv
// Shared state encoding and counter sizing helper for button_event_decoder.
package btn_pkg;

  typedef logic [1:0] btn_state_t;

  localparam btn_state_t IDLE = 2'd0;
  localparam btn_state_t HELD = 2'd1;
  localparam btn_state_t LONG = 2'd2;

  // Bits needed to hold 0..max_val, never fewer than one.
  function automatic int cnt_width(input int max_val);
    int w;
    w = $clog2(max_val + 1);
    if (w < 1) begin
      w = 1;
    end else begin
      w = w;
    end
    return w;
  endfunction

endpackage

// File: rtl/button_event_decoder_tick_prescaler.sv
// Divides the clock into a one-cycle tick every TICK_DIV enabled cycles.
module tick_prescaler
  import btn_pkg::*;
#(
  parameter int TICK_DIV = 1000
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int W = cnt_width(TICK_DIV - 1);
  localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

  logic [W-1:0] count;

  assign tick = enable & ~clear & (count == LAST);

  // Clear wins over enable; the count wraps to zero on the tick cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      if (count == LAST) begin
        count <= '0;
      end else begin
        count <= count + W'(1);
      end
    end else begin
      count <= count;
    end
  end

endmodule

// File: rtl/button_event_decoder.sv
// Turns a debounced button level into press/release/long-press/repeat pulses and a held level.
// Auto-repeat in the long-held state is built only when BTN_AUTOREPEAT_EN is defined.
module button_event_decoder
  import btn_pkg::*;
#(
  parameter int TICK_DIV     = 1000,
  parameter int LONG_TICKS   = 500,
  parameter int REPEAT_TICKS = 100
) (
  input  logic clock,
  input  logic reset,
  input  logic in,
  output logic press,
  output logic release_pulse,
  output logic long_press,
  output logic repeat_pulse,
  output logic held
);

`ifdef BTN_AUTOREPEAT_EN
  localparam int TICK_MAX = (LONG_TICKS > REPEAT_TICKS) ? LONG_TICKS : REPEAT_TICKS;
`else
  localparam int TICK_MAX = LONG_TICKS;
`endif
  localparam int TW = cnt_width(TICK_MAX);
  localparam logic [TW-1:0] LONG_LAST = TW'(LONG_TICKS - 1);
`ifdef BTN_AUTOREPEAT_EN
  localparam logic [TW-1:0] REP_LAST = TW'(REPEAT_TICKS - 1);
`endif

  if (TICK_DIV < 1 || LONG_TICKS < 1 || REPEAT_TICKS < 1) begin : g_param_check
    $error("button_event_decoder: TICK_DIV, LONG_TICKS and REPEAT_TICKS must be >= 1");
  end

  btn_state_t    state, state_next;
  logic [TW-1:0] ticks, ticks_next;
  logic          prev, armed, rise, fall, tick;
  logic          presc_clear, presc_enable;
  logic          press_next, release_next, long_next, repeat_next;

  assign rise        = in & ~prev & armed;
  assign fall        = ~in & prev;
  assign presc_clear = (state == IDLE) & rise;
`ifdef BTN_AUTOREPEAT_EN
  assign presc_enable = (state == HELD) | (state == LONG);
`else
  assign presc_enable = (state == HELD);
`endif

  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
    .clock  (clock),
    .reset  (reset),
    .clear  (presc_clear),
    .enable (presc_enable),
    .tick   (tick)
  );

  // Next-state and pulse decisions; fall is checked first so it beats a coinciding threshold tick.
  always_comb begin
    state_next   = state;
    ticks_next   = ticks;
    press_next   = 1'b0;
    release_next = 1'b0;
    long_next    = 1'b0;
    repeat_next  = 1'b0;
    case (state)
      IDLE: begin
        if (rise) begin
          state_next = HELD;
          ticks_next = '0;
          press_next = 1'b1;
        end else begin
          state_next = IDLE;
        end
      end
      HELD: begin
        if (fall) begin
          state_next   = IDLE;
          release_next = 1'b1;
        end else if (tick) begin
          if (ticks == LONG_LAST) begin
            state_next = LONG;
            ticks_next = '0;
            long_next  = 1'b1;
          end else if (ticks == {TW{1'b1}}) begin
            ticks_next = ticks;
          end else begin
            ticks_next = ticks + TW'(1);
          end
        end else begin
          state_next = HELD;
        end
      end
      LONG: begin
        if (fall) begin
          state_next   = IDLE;
          release_next = 1'b1;
`ifdef BTN_AUTOREPEAT_EN
        end else if (tick) begin
          if (ticks == REP_LAST) begin
            ticks_next  = '0;
            repeat_next = 1'b1;
          end else if (ticks == {TW{1'b1}}) begin
            ticks_next = ticks;
          end else begin
            ticks_next = ticks + TW'(1);
          end
`endif
        end else begin
          state_next = LONG;
        end
      end
      default: begin
        state_next = IDLE;
        ticks_next = '0;
      end
    endcase
  end

  // Edge history, arming, FSM state and registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      prev          <= 1'b0;
      armed         <= 1'b0;
      state         <= IDLE;
      ticks         <= '0;
      press         <= 1'b0;
      release_pulse <= 1'b0;
      long_press    <= 1'b0;
      repeat_pulse  <= 1'b0;
      held          <= 1'b0;
    end else begin
      prev          <= in;
      armed         <= armed | ~in;
      state         <= state_next;
      ticks         <= ticks_next;
      press         <= press_next;
      release_pulse <= release_next;
      long_press    <= long_next;
      repeat_pulse  <= repeat_next;
      held          <= (state_next != IDLE);
    end
  end

endmodule
